alu_cmd_seq: RTL and testbench
==============================

# alu_cmd_seq

Upstream command sequencer for the combinational four-operation integer/float arithmetic unit (add/sub/mul/div selected by `s`, domain by `float`). It buffers operation requests in a small FIFO and holds each operand set stable on the unit's inputs for a programmable settle window. It then captures `{car, outh, out}` into a registered response port with valid/ready handshake. This turns the unit's long combinational paths into a controlled multicycle path and gives the datapath in-order, backpressure-aware issue.

## Interface
- `N`, 32, operand/result width.
- `DEPTH`, 4, request FIFO entries; power of two, ≥2.
- `SETTLE`, 2, cycles operands are held on the unit before capture; ≥1.
- `TAGW`, 4, width of opaque request tag.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request FIFO not full.
- `req_a`, `req_b`  in  N  operands.
- `req_s`  in  2  op select: 00 add, 01 sub, 10 mul, 11 div.
- `req_float`  in  1  1 = float domain.
- `req_tag`  in  TAGW  returned unchanged with the result.
- `alu_a`, `alu_b`  out  N  registered operands to the unit.
- `alu_s`  out  2  registered op select.
- `alu_float`  out  1  registered domain select.
- `alu_car`  in  1  unit carry/borrow.
- `alu_outh`  in  N  unit high result word.
- `alu_out`  in  N  unit low result word.
- `rsp_valid`  out  1  response held.
- `rsp_ready`  in  1  consumer accepts.
- `rsp_out`, `rsp_outh`  out  N  captured results.
- `rsp_car`  out  1  captured carry.
- `rsp_tag`  out  TAGW  tag of the captured request.
- `rsp_float`  out  1  domain of the captured request.
- `count`  out  $clog2(DEPTH)+1  FIFO occupancy.
- `busy`  out  1  FIFO non-empty, or state ≠ IDLE, or `rsp_valid`.

## Operation
- Push on `req_valid && req_ready`. `req_ready = (count != DEPTH)`; it does not depend on a same-cycle pop.
- A push and a pop in the same cycle leave `count` unchanged. There is no FIFO bypass: a request pushed at an edge is poppable from the next cycle.
- State machine:
  - **IDLE**: if the FIFO is non-empty at the edge, pop the head into the `alu_*`/tag registers, load `cnt = SETTLE-1`, and go to EXEC.
  - **EXEC**: if `cnt != 0`, decrement `cnt`. If `cnt == 0` and the response slot is free (`!rsp_valid || rsp_ready`), capture at the edge. On capture, if the FIFO is non-empty, pop the next request and reload `cnt` (stay in EXEC); otherwise go to IDLE. If `cnt == 0` and the slot is not free, go to WAIT.
  - **WAIT**: operands stay held. When the slot frees, capture, then pop/reload as in EXEC.
- Capture loads `rsp_out <= alu_out`, `rsp_outh <= alu_outh`, `rsp_car <= alu_car`, plus the tag and float of the operand registers, and sets `rsp_valid`.
- `rsp_valid` clears on `rsp_ready` unless a capture happens at the same edge, in which case it stays 1 with the new data.
- `alu_*` change only at pop edges. Between pops they hold the last issued operands; they are never zeroed after use.
- Ordering is strictly in order. Tags are opaque to this block.

## Timing
- Reset values: `alu_a`, `alu_b`, `alu_s`, `alu_float`, all `rsp_*` = 0; `rsp_valid` = 0; `count` = 0; `busy` = 0; state IDLE; `cnt` = 0. `req_ready` = 1 while `rst_n` is low and after reset.
- Reset asserted mid-operation discards the FIFO, the in-flight operation and any held response immediately. No response is produced for them.
- Latency: a request accepted at edge t into an empty, idle block is popped at t+1 and captured at t+1+SETTLE. `rsp_valid` is high from t+1+SETTLE, i.e. SETTLE+1 cycles after acceptance.
- Throughput with `rsp_ready = 1` and a non-empty FIFO: one result every SETTLE cycles.
- Storage: with `rsp_ready` held 0, the block accepts DEPTH+2 requests: DEPTH in the FIFO, one in WAIT, one in the response register.

## Test plan
- Integer add, SETTLE=2: a=5, b=7, s=00, float=0, tag=3 → `rsp_out=12`, `rsp_car=0`, `rsp_tag=3`; `rsp_valid` rises exactly 3 cycles after the accept edge.
- Carry/sub: a=0xFFFFFFFF, b=1, s=00 → `rsp_out=0`, `rsp_car=1`. Then a=10, b=3, s=01 → `rsp_out=7`, in order behind the first.
- Float multiply: a=0x40000000, b=0x40400000, s=10, float=1 → `rsp_out=0x40C00000`, `rsp_float=1`.
- Backpressure, DEPTH=4: hold `rsp_ready=0` and offer 8 requests with tags 0..7.
  - Exactly 6 are accepted; `req_ready` goes low; `count=4`; state WAIT.
  - Then release `rsp_ready`: tags 0..5 emerge in order, followed by the remaining 2 after they are accepted.
- Streaming, SETTLE=1: `rsp_ready=1`, 8 back-to-back requests → 8 responses on consecutive cycles; `count` never exceeds 1.
- Reset mid-op: drop `rst_n` while in EXEC with `count=2` → all outputs return to their reset values asynchronously, no stale response after release, and the next request completes normally.

Source files
------------

// File: rtl/alu_cmd_seq.sv
// alu_cmd_seq: in-order request FIFO and settle-window sequencer
// driving a combinational arithmetic unit, with registered response.
module alu_cmd_seq #(
    parameter int N      = 32,
    parameter int DEPTH  = 4,
    parameter int SETTLE = 2,
    parameter int TAGW   = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [N-1:0]             req_a,
    input  logic [N-1:0]             req_b,
    input  logic [1:0]               req_s,
    input  logic                     req_float,
    input  logic [TAGW-1:0]          req_tag,
    output logic [N-1:0]             alu_a,
    output logic [N-1:0]             alu_b,
    output logic [1:0]               alu_s,
    output logic                     alu_float,
    input  logic                     alu_car,
    input  logic [N-1:0]             alu_outh,
    input  logic [N-1:0]             alu_out,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [N-1:0]             rsp_out,
    output logic [N-1:0]             rsp_outh,
    output logic                     rsp_car,
    output logic [TAGW-1:0]          rsp_tag,
    output logic                     rsp_float,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int KW = $clog2(SETTLE + 1);
    localparam int EW = 2 * N + 3 + TAGW;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_WAIT
    } state_t;

    state_t          state;
    logic [KW-1:0]   cnt;
    logic [TAGW-1:0] op_tag;

    logic [EW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;

    logic [N-1:0]    h_a;
    logic [N-1:0]    h_b;
    logic [1:0]      h_s;
    logic            h_f;
    logic [TAGW-1:0] h_tag;

    logic push;
    logic pop;
    logic fifo_ne;
    logic slot_free;
    logic capture;

    assign req_ready = (count != CW'(DEPTH));
    assign push      = req_valid && req_ready;
    assign fifo_ne   = (count != '0);
    assign slot_free = !rsp_valid || rsp_ready;

    // A result is captured when the settle window has expired and
    // the response register can take it; the next pop rides along.
    always_comb begin
        capture = 1'b0;
        pop     = 1'b0;
        unique case (state)
            S_IDLE: pop = fifo_ne;
            S_EXEC: capture = (cnt == '0) && slot_free;
            S_WAIT: capture = slot_free;
            default: capture = 1'b0;
        endcase
        if (capture) begin
            pop = fifo_ne;
        end
    end

    assign {h_a, h_b, h_s, h_f, h_tag} = mem[rd_ptr];

    assign busy = fifo_ne || (state != S_IDLE) || rsp_valid;

    // FIFO storage; contents are only read while occupancy is nonzero.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {req_a, req_b, req_s, req_float, req_tag};
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Issue/settle/capture state machine with its registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            op_tag    <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_s     <= '0;
            alu_float <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_out   <= '0;
            rsp_outh  <= '0;
            rsp_car   <= 1'b0;
            rsp_tag   <= '0;
            rsp_float <= 1'b0;
        end else begin
            if (capture) begin
                rsp_valid <= 1'b1;
                rsp_out   <= alu_out;
                rsp_outh  <= alu_outh;
                rsp_car   <= alu_car;
                rsp_tag   <= op_tag;
                rsp_float <= alu_float;
            end else if (rsp_ready) begin
                rsp_valid <= 1'b0;
            end
            if (pop) begin
                alu_a     <= h_a;
                alu_b     <= h_b;
                alu_s     <= h_s;
                alu_float <= h_f;
                op_tag    <= h_tag;
                cnt       <= KW'(SETTLE - 1);
            end
            unique case (state)
                S_IDLE: begin
                    if (fifo_ne) begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (cnt != '0) begin
                        cnt <= cnt - KW'(1);
                    end else if (slot_free) begin
                        state <= fifo_ne ? S_EXEC : S_IDLE;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (slot_free) begin
                        state <= fifo_ne ? S_EXEC : S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_seq.sv
// tb_alu_cmd_seq: scoreboard bench for alu_cmd_seq with a behavioural
// arithmetic unit; a second instance runs with a one-cycle settle window.
module tb_alu_cmd_seq;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        req_valid, req_ready, req_float;
    logic [31:0] req_a, req_b;
    logic [1:0]  req_s;
    logic [3:0]  req_tag;
    logic [31:0] alu_a, alu_b, alu_outh, alu_out;
    logic [1:0]  alu_s;
    logic        alu_float, alu_car;
    logic        rsp_valid, rsp_ready, rsp_car, rsp_float;
    logic [31:0] rsp_out, rsp_outh;
    logic [3:0]  rsp_tag;
    logic [2:0]  count;
    logic        busy;

    logic        s_req_valid, s_req_ready, s_req_float;
    logic [31:0] s_req_a, s_req_b;
    logic [1:0]  s_req_s;
    logic [3:0]  s_req_tag;
    logic [31:0] s_alu_a, s_alu_b, s_alu_outh, s_alu_out;
    logic [1:0]  s_alu_s;
    logic        s_alu_float, s_alu_car;
    logic        s_rsp_valid, s_rsp_ready, s_rsp_car, s_rsp_float;
    logic [31:0] s_rsp_out, s_rsp_outh;
    logic [3:0]  s_rsp_tag;
    logic [2:0]  s_count;
    logic        s_busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;

    logic [69:0] exp_q[$];
    logic [69:0] exp1_q[$];

    logic [31:0] last_out;
    logic        last_car;
    logic [3:0]  last_tag;
    logic        last_float;

    int nv1 = 0, first1 = -1, lastv1 = -1, maxc1 = 0, acc1 = 0;

    logic [31:0] ftab [6] = '{32'h3F800000, 32'h40000000, 32'h40400000,
                              32'hC0A00000, 32'h3E800000, 32'h42C80000};

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    alu_cmd_seq #(.N(32), .DEPTH(4), .SETTLE(2), .TAGW(4)) u0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_s(req_s),
        .req_float(req_float), .req_tag(req_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_float(alu_float),
        .alu_car(alu_car), .alu_outh(alu_outh), .alu_out(alu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_out(rsp_out), .rsp_outh(rsp_outh), .rsp_car(rsp_car),
        .rsp_tag(rsp_tag), .rsp_float(rsp_float),
        .count(count), .busy(busy)
    );

    alu_cmd_seq #(.N(32), .DEPTH(4), .SETTLE(1), .TAGW(4)) u1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(s_req_valid), .req_ready(s_req_ready),
        .req_a(s_req_a), .req_b(s_req_b), .req_s(s_req_s),
        .req_float(s_req_float), .req_tag(s_req_tag),
        .alu_a(s_alu_a), .alu_b(s_alu_b), .alu_s(s_alu_s),
        .alu_float(s_alu_float),
        .alu_car(s_alu_car), .alu_outh(s_alu_outh), .alu_out(s_alu_out),
        .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready),
        .rsp_out(s_rsp_out), .rsp_outh(s_rsp_outh), .rsp_car(s_rsp_car),
        .rsp_tag(s_rsp_tag), .rsp_float(s_rsp_float),
        .count(s_count), .busy(s_busy)
    );

    function automatic real f2d(input logic [31:0] x);
        logic [10:0] e;
        if (x[30:23] == 8'd0) return 0.0;
        e = 11'(x[30:23]) + 11'd896;
        return $bitstoreal({x[31], e, x[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] d2f(input real r);
        logic [63:0] d;
        int ee;
        d = $realtobits(r);
        ee = int'(d[62:52]) - 1023 + 127;
        if (d[62:52] == 11'd0 || ee <= 0) return {d[63], 31'd0};
        if (ee >= 255) return {d[63], 8'hFF, 23'd0};
        return {d[63], ee[7:0], d[51:29]};
    endfunction

    // Behavioural arithmetic unit: returns {car, outh, out}.
    function automatic logic [64:0] unit(input logic [31:0] a, b,
                                         input logic [1:0] s,
                                         input logic f);
        logic [32:0] sum;
        logic [63:0] prod;
        real ra, rb, r;
        if (f) begin
            ra = f2d(a);
            rb = f2d(b);
            case (s)
                2'd0: r = ra + rb;
                2'd1: r = ra - rb;
                2'd2: r = ra * rb;
                default: r = ra / rb;
            endcase
            return {1'b0, 32'd0, d2f(r)};
        end
        case (s)
            2'd0: begin
                sum = {1'b0, a} + {1'b0, b};
                return {sum[32], 32'd0, sum[31:0]};
            end
            2'd1: return {(a < b), 32'd0, a - b};
            2'd2: begin
                prod = 64'(a) * 64'(b);
                return {1'b0, prod};
            end
            default: begin
                if (b == 0) return {1'b0, a, 32'hFFFFFFFF};
                return {1'b0, a % b, a / b};
            end
        endcase
    endfunction

    always_comb {alu_car, alu_outh, alu_out} = unit(alu_a, alu_b, alu_s, alu_float);
    always_comb {s_alu_car, s_alu_outh, s_alu_out} =
        unit(s_alu_a, s_alu_b, s_alu_s, s_alu_float);

    task automatic check(input string nm, input logic [127:0] act,
                         input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    // Scoreboard for the SETTLE=2 instance.
    always @(negedge clk) begin
        if (rst_n) begin
            if (req_valid && req_ready)
                exp_q.push_back({req_tag, req_float,
                                 unit(req_a, req_b, req_s, req_float)});
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", {rsp_tag, rsp_out}, 128'hX);
                end else begin
                    check("rsp", {rsp_tag, rsp_float, rsp_car, rsp_outh, rsp_out},
                          exp_q.pop_front());
                end
                last_out   = rsp_out;
                last_car   = rsp_car;
                last_tag   = rsp_tag;
                last_float = rsp_float;
            end
        end
    end

    // Scoreboard and streaming statistics for the SETTLE=1 instance.
    always @(negedge clk) begin
        if (rst_n) begin
            if (s_req_valid && s_req_ready) begin
                acc1++;
                exp1_q.push_back({s_req_tag, s_req_float,
                                  unit(s_req_a, s_req_b, s_req_s, s_req_float)});
            end
            if (int'(s_count) > maxc1) maxc1 = int'(s_count);
            if (s_rsp_valid) begin
                nv1++;
                if (first1 < 0) first1 = cyc;
                lastv1 = cyc;
            end
            if (s_rsp_valid && s_rsp_ready) begin
                if (exp1_q.size() == 0) begin
                    check("s_rsp_unexpected", {s_rsp_tag, s_rsp_out}, 128'hX);
                end else begin
                    check("s_rsp", {s_rsp_tag, s_rsp_float, s_rsp_car,
                                    s_rsp_outh, s_rsp_out}, exp1_q.pop_front());
                end
            end
        end
    end

    task automatic send(input logic [31:0] a, b, input logic [1:0] s,
                        input logic f, input logic [3:0] t);
        bit ok;
        ok = 1'b0;
        req_a = a; req_b = b; req_s = s; req_float = f; req_tag = t;
        req_valid = 1'b1;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            ok = req_ready;
            @(posedge clk);
            #1;
        end
        if (ok) acc_cyc = cyc;
        req_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout tag=%0d act=stuck exp=accepted", t);
        end
    endtask

    task automatic wait_drain(input string nm);
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) break;
        end
        check(nm, {exp_q.size() != 0, busy}, 0);
    endtask

    task automatic rst_outs(input string nm);
        check({nm, "_ops"}, {alu_a, alu_b, alu_s, alu_float}, 0);
        check({nm, "_rsp"}, {rsp_out, rsp_outh, rsp_car, rsp_tag,
                             rsp_float, rsp_valid}, 0);
        check({nm, "_ctl"}, {count, busy, req_ready}, {3'd0, 1'b0, 1'b1});
    endtask

    logic [31:0] bp_a [8];
    logic [31:0] bp_b [8];
    logic [1:0]  bp_s [8];
    int          lat, acc, tg;
    bit          ready_s, stale, rnd_on;

    initial begin
        rst_n = 1'b0;
        req_valid = 0; req_a = 0; req_b = 0; req_s = 0; req_float = 0; req_tag = 0;
        rsp_ready = 1'b1;
        s_req_valid = 0; s_req_a = 0; s_req_b = 0; s_req_s = 0;
        s_req_float = 0; s_req_tag = 0;
        s_rsp_ready = 1'b1;
        #3;
        rst_outs("reset");
        #9 rst_n = 1'b1;
        @(posedge clk); #1;

        // Integer add with latency measurement.
        send(32'd5, 32'd7, 2'd0, 1'b0, 4'd3);
        lat = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat = cyc - acc_cyc;
                break;
            end
        end
        check("latency", lat, 3);
        wait_drain("drain_add");
        check("add_result", {last_out, last_car, last_tag}, {32'd12, 1'b0, 4'd3});
        @(posedge clk); #1;

        // Carry-out then subtraction, in order.
        send(32'hFFFFFFFF, 32'd1, 2'd0, 1'b0, 4'd1);
        wait_drain("drain_carry");
        check("carry_result", {last_out, last_car}, {32'd0, 1'b1});
        @(posedge clk); #1;
        send(32'd10, 32'd3, 2'd1, 1'b0, 4'd2);
        wait_drain("drain_sub");
        check("sub_result", {last_out, last_tag}, {32'd7, 4'd2});
        @(posedge clk); #1;

        // Float multiply 2.0 * 3.0.
        send(32'h40000000, 32'h40400000, 2'd2, 1'b1, 4'd5);
        wait_drain("drain_fmul");
        check("fmul_result", {last_out, last_float}, {32'h40C00000, 1'b1});
        @(posedge clk); #1;

        // Backpressure: response consumer stalled.
        for (int i = 0; i < 8; i++) begin
            bp_a[i] = $urandom; bp_b[i] = $urandom; bp_s[i] = 2'($urandom);
        end
        rsp_ready = 1'b0;
        acc = 0; tg = 0;
        req_a = bp_a[0]; req_b = bp_b[0]; req_s = bp_s[0];
        req_float = 1'b0; req_tag = 4'd0; req_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            ready_s = req_ready;
            @(posedge clk); #1;
            if (ready_s) begin
                acc++; tg++;
                req_a = bp_a[tg % 8]; req_b = bp_b[tg % 8];
                req_s = bp_s[tg % 8]; req_tag = 4'(tg);
            end
        end
        check("bp_accepted", acc, 6);
        check("bp_full", {req_ready, count}, {1'b0, 3'd4});
        check("bp_rsp_held", {rsp_valid, rsp_tag}, {1'b1, 4'd0});
        check("bp_wait_ops", {alu_a, alu_b, alu_s}, {bp_a[1], bp_b[1], bp_s[1]});
        rsp_ready = 1'b1;
        for (int k = 0; k < 60 && acc < 8; k++) begin
            @(negedge clk);
            ready_s = req_ready;
            @(posedge clk); #1;
            if (ready_s) begin
                acc++; tg++;
                req_a = bp_a[tg % 8]; req_b = bp_b[tg % 8];
                req_s = bp_s[tg % 8]; req_tag = 4'(tg);
            end
        end
        req_valid = 1'b0;
        check("bp_all_accepted", acc, 8);
        wait_drain("drain_bp");
        check("bp_last_tag", last_tag, 4'd7);
        @(posedge clk); #1;

        // Streaming on the SETTLE=1 instance.
        nv1 = 0; first1 = -1; lastv1 = -1; maxc1 = 0; acc1 = 0;
        s_req_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            s_req_a = $urandom; s_req_b = $urandom; s_req_s = 2'($urandom);
            s_req_float = 1'b0; s_req_tag = 4'(i);
            @(posedge clk); #1;
        end
        s_req_valid = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("stream_accepted", acc1, 8);
        check("stream_nvalid", nv1, 8);
        check("stream_consecutive", lastv1 - first1, 7);
        check("stream_maxcount", maxc1 <= 1, 1);
        check("stream_drained", exp1_q.size(), 0);

        // Randomized traffic with random response backpressure.
        rnd_on = 1'b1;
        fork
            begin
                for (int k = 0; k < 5000 && rnd_on; k++) begin
                    @(posedge clk); #1;
                    rsp_ready = ($urandom_range(0, 3) != 0);
                end
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    logic f;
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk); #1;
                    end
                    f = ($urandom_range(0, 3) == 0);
                    send(f ? ftab[$urandom_range(0, 5)] : $urandom,
                         f ? ftab[$urandom_range(0, 5)] : $urandom,
                         2'($urandom), f, 4'($urandom));
                end
                rnd_on = 1'b0;
            end
        join
        rsp_ready = 1'b1;
        wait_drain("drain_random");
        @(posedge clk); #1;

        // Reset in the middle of an operation.
        send(32'd1, 32'd1, 2'd0, 1'b0, 4'd8);
        send(32'd2, 32'd2, 2'd0, 1'b0, 4'd9);
        send(32'd3, 32'd3, 2'd0, 1'b0, 4'd10);
        check("midop_count", count, 3'd2);
        #2 rst_n = 1'b0;
        #1;
        rst_outs("midop_reset");
        exp_q.delete();
        @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        stale = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rsp_valid) stale = 1'b1;
        end
        check("no_stale_rsp", stale, 0);
        @(posedge clk); #1;
        send(32'd40, 32'd2, 2'd0, 1'b0, 4'd12);
        wait_drain("drain_after_reset");
        check("after_reset_result", {last_out, last_tag}, {32'd42, 4'd12});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
